// File: rtl/modular_multiplier.sv
// Interleaved MSB-first shift-add modular multiplier: c = (a*b) mod m, one bit of a per clock.
// Operands are latched on the accept edge; the partial product P stays below m after every step.
module modular_multiplier #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] c,
  output logic             ready,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is a level request sampled only in S_IDLE; ready is a one-cycle
  // pulse during which c and err are valid; busy covers S_RUN and S_DONE, and all
  // inputs are ignored while busy.

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, b_q, m_q, p_q;
  logic [CW-1:0]    cnt;

  logic             in_err;
  logic [WIDTH:0]   dbl;
  logic [WIDTH-1:0] dbl_red;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] p_next;

  assign in_err = (m == '0) || (b >= m);

  // One iteration: P = 2P mod m, then conditionally P = (P + b) mod m.
  // Both sums stay below 2m, so a single conditional subtraction suffices.
  always_comb begin
    dbl     = {p_q, 1'b0};
    dbl_red = WIDTH'((dbl >= {1'b0, m_q}) ? (dbl - {1'b0, m_q}) : dbl);
    sum     = {1'b0, dbl_red} + (a_q[cnt] ? {1'b0, b_q} : '0);
    p_next  = WIDTH'((sum >= {1'b0, m_q}) ? (sum - {1'b0, m_q}) : sum);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = in_err ? S_DONE : S_RUN;
      S_RUN:  if (cnt == '0) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      p_q   <= '0;
      cnt   <= '0;
      c     <= '0;
      err   <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= next_state;
      ready <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            m_q <= m;
            p_q <= '0;
            cnt <= CW'(WIDTH - 1);
            err <= in_err;
            if (in_err) c <= '0;
          end
        end
        S_RUN: begin
          p_q <= p_next;
          if (cnt == '0) c <= p_next;
          else           cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_multiplier.sv
// Directed and randomised bench for modular_multiplier (WIDTH=256): results, err path,
// latency, mid-run reset, input isolation while busy and back-to-back operation.
module tb_modular_multiplier;

  localparam int W = 256;
  localparam logic [W-1:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, m, c;
  logic         ready, busy, err;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  modular_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m),
    .c(c), .ready(ready), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [W-1:0] n);
    logic [2*W-1:0] p;
    logic [2*W-1:0] r;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    r = p % {{W{1'b0}}, n};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // lat = number of clock edges from the accept edge to the edge that raises ready;
  // -1 if ready never appears within the budget.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W-1:0] mi,
                        output logic [W-1:0] co, output logic eo, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 2 * W) begin
      @(negedge clk);
      w++;
    end
    a = ai; b = bi; m = mi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    co  = '0;
    eo  = 1'bx;
    for (int n = 1; n <= W + 20; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n - 1;
        co  = c;
        eo  = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
    repeat (3) @(negedge clk);
    checks++; if (c !== '0)           begin errors++; $display("FAIL reset_c: got %h want 0", c); end
    checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] r; logic e; int lat;
    run_op(256'hbe, 256'd1, 256'd367, r, e, lat);
    checks++; if (r !== 256'hbe)  begin errors++; $display("FAIL basic_c: got %h want be", r); end
    checks++; if (e !== 1'b0)     begin errors++; $display("FAIL basic_err: got %b want 0", e); end
    checks++; if (lat !== W + 1)  begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_pulse_width: got %b want 0", ready); end
    run_op(256'd190, 256'd226, 256'd367, r, e, lat);
    checks++; if (r !== 256'd1)   begin errors++; $display("FAIL inverse_check: got %0d want 1", r); end
    run_op(256'd190, 256'd190, 256'd367, r, e, lat);
    checks++; if (r !== 256'd134) begin errors++; $display("FAIL square_190: got %0d want 134", r); end
  endtask

  task automatic test_wide();
    logic [W-1:0] r, exp_c; logic e; int lat;
    run_op(P256 - 1, P256 - 1, P256, r, e, lat);
    checks++; if (r !== 256'd1) begin errors++; $display("FAIL p256_minus1_sq: got %h want 1", r); end
    exp_c = ref_mulmod('1, 256'd2, 256'd367);
    run_op('1, 256'd2, 256'd367, r, e, lat);
    checks++; if (r !== exp_c)  begin errors++; $display("FAIL a_ge_m: got %0d want %0d", r, exp_c); end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r; logic e; int lat; int seen;
    @(negedge clk);
    a = 256'd190; b = 256'd226; m = 256'd367; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    checks++; if (c !== '0)      begin errors++; $display("FAIL async_reset_c: got %h want 0", c); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < W + 10; n++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL aborted_op_ready: got %0d pulses want 0", seen); end
    run_op(256'd5, 256'd7, 256'd11, r, e, lat);
    checks++; if (r !== 256'd2)  begin errors++; $display("FAIL restart_c: got %0d want 2", r); end
    checks++; if (lat !== W + 1) begin errors++; $display("FAIL restart_latency: got %0d want %0d", lat, W + 1); end
  endtask

  task automatic test_errors();
    logic [W-1:0] r; logic e; int lat;
    run_op(256'd5, 256'd7, 256'd11, r, e, lat);
    run_op(256'd5, 256'd7, 256'd0, r, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL m_zero_err: got %b want 1", e); end
    checks++; if (r !== '0)   begin errors++; $display("FAIL m_zero_c: got %h want 0", r); end
    checks++; if (lat !== 1)  begin errors++; $display("FAIL m_zero_latency: got %0d want 1", lat); end
    run_op(256'd5, 256'd7, 256'd11, r, e, lat);
    run_op(256'd5, 256'd367, 256'd367, r, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL b_eq_m_err: got %b want 1", e); end
    checks++; if (r !== '0)   begin errors++; $display("FAIL b_eq_m_c: got %h want 0", r); end
    run_op(256'd12345, 256'd0, 256'd1, r, e, lat);
    checks++; if (r !== '0 || e !== 1'b0) begin errors++; $display("FAIL m_one: got c=%h err=%b want c=0 err=0", r, e); end
    run_op(256'd0, 256'd200, 256'd367, r, e, lat);
    checks++; if (r !== '0 || e !== 1'b0) begin errors++; $display("FAIL a_zero: got c=%h err=%b want c=0 err=0", r, e); end
  endtask

  task automatic test_ignore_inputs();
    logic [W-1:0] r; logic e; int lat; int c_changed; int got;
    run_op(256'd190, 256'd190, 256'd367, r, e, lat);
    @(negedge clk);
    a = 256'd190; b = 256'd226; m = 256'd367; start = 1'b1;
    @(posedge clk);
    #1;
    c_changed = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      start = ~start;
      a = rand_wide(); b = rand_wide(); m = rand_wide();
      if (c !== 256'd134) c_changed++;
    end
    start = 1'b0;
    checks++; if (c_changed !== 0) begin errors++; $display("FAIL c_hold_during_run: got %0d changes want 0", c_changed); end
    got = 0;
    for (int n = 0; n < W + 10 && got == 0; n++) begin
      @(negedge clk);
      if (ready) begin
        got = 1;
        r = c;
      end
    end
    checks++; if (got !== 1 || r !== 256'd1) begin errors++; $display("FAIL ignore_inputs_c: got %0d (ready=%0d) want 1", r, got); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] want;
    int stamp[3];
    int np;
    exp_q = {256'd2, 256'd134, 256'd1};
    np = 0;
    @(negedge clk);
    a = 256'd5; b = 256'd7; m = 256'd11; start = 1'b1;
    for (int n = 0; n < 3 * (W + 2) + 20 && np < 3; n++) begin
      @(negedge clk);
      if (ready) begin
        stamp[np] = cyc;
        want = exp_q.pop_front();
        checks++; if (c !== want) begin errors++; $display("FAIL b2b_c%0d: got %0d want %0d", np, c, want); end
        np++;
        if (np == 1) begin a = 256'd190; b = 256'd190; m = 256'd367; end
        if (np == 2) begin a = 256'd190; b = 256'd226; m = 256'd367; end
        if (np == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++; if (np !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", np); end
    if (np == 3) begin
      checks++; if (stamp[1] - stamp[0] !== W + 2) begin errors++; $display("FAIL b2b_spacing1: got %0d want %0d", stamp[1] - stamp[0], W + 2); end
      checks++; if (stamp[2] - stamp[1] !== W + 2) begin errors++; $display("FAIL b2b_spacing2: got %0d want %0d", stamp[2] - stamp[1], W + 2); end
    end
  endtask

  task automatic test_random(input int nvec);
    logic [W-1:0] ra, rb, rm, r, exp_c; logic e; int lat;
    for (int v = 0; v < nvec; v++) begin
      ra = rand_wide();
      if (v % 2 == 0) rm = W'($urandom_range(1, 1000));
      else            rm = rand_wide();
      if (rm == '0) rm = 256'd1;
      rb = rand_wide() % rm;
      exp_c = ref_mulmod(ra, rb, rm);
      run_op(ra, rb, rm, r, e, lat);
      checks++;
      if (r !== exp_c || e !== 1'b0 || lat !== W + 1) begin
        errors++;
        $display("FAIL random_%0d: got c=%h err=%b lat=%0d want c=%h err=0 lat=%0d", v, r, e, lat, exp_c, W + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_reset_mid_run();
    test_errors();
    test_ignore_inputs();
    test_back_to_back();
    test_random(100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
